rename_table: RTL

- Register alias table for the rename stage.
- Consumes the two physical registers produced each cycle by the free list and maps architectural destinations onto them.
- Supplies source mappings and ready bits downstream toward issue, and the old destination mapping for later release at commit.
- Keeps NUM_CHECKPOINTS speculative copies using the same checkpoint labelling as the free list, so one recover label restores both. A committed map provides exception rollback.

---
 rtl/rename_table_pkg.sv | 43 ++++
 rtl/rename_table_ready_vector.sv | 53 +++++
 rtl/rename_table.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rename_table_pkg.sv
// -----------------------------------------------------------------------------
// rename_table_pkg
// Shared types and constants for the register alias table (rename stage).
//   reg_t          : architectural register index
//   phreg_t        : physical register index
//   checkpoint_ptr : speculative map copy label (same labelling as the free list)
//   num_cp_t       : live checkpoint count, one bit wider than checkpoint_ptr
// Optional build macro used by rename_table: RENAME_TABLE_CHECK_EN.
// -----------------------------------------------------------------------------
package rename_table_pkg;

  localparam int NUM_ISA_REGISTERS      = 32;
  localparam int NUM_PHISICAL_REGISTERS = 64;
  localparam int NUM_CHECKPOINTS        = 4;

  localparam int REG_W   = $clog2(NUM_ISA_REGISTERS);
  localparam int PHREG_W = $clog2(NUM_PHISICAL_REGISTERS);
  localparam int CP_W    = $clog2(NUM_CHECKPOINTS);

  typedef logic [REG_W-1:0]   reg_t;
  typedef logic [PHREG_W-1:0] phreg_t;
  typedef logic [CP_W-1:0]    checkpoint_ptr;
  typedef logic [CP_W:0]      num_cp_t;

  localparam checkpoint_ptr LAST_CP     = checkpoint_ptr'(NUM_CHECKPOINTS - 1);
  localparam num_cp_t       MAX_LIVE_CP = num_cp_t'(NUM_CHECKPOINTS - 1);
  localparam num_cp_t       NUM_CP      = num_cp_t'(NUM_CHECKPOINTS);

  // Checkpoint labels form a ring of NUM_CHECKPOINTS entries.
  function automatic checkpoint_ptr cp_inc(input checkpoint_ptr p);
    return (p == LAST_CP) ? '0 : checkpoint_ptr'(p + 1'b1);
  endfunction

  // Number of ring steps from from_p forward to to_p.
  function automatic num_cp_t cp_distance(input checkpoint_ptr from_p,
                                          input checkpoint_ptr to_p);
    if (to_p >= from_p)
      return num_cp_t'(to_p) - num_cp_t'(from_p);
    else
      return NUM_CP - num_cp_t'(from_p) + num_cp_t'(to_p);
  endfunction

endpackage

// File: rtl/rename_table_ready_vector.sv
// -----------------------------------------------------------------------------
// rename_table_ready_vector
// Global physical-register ready bits for the rename stage.
//   i_clk, i_rstn   : clock, asynchronous active-low reset (all bits ready)
//   i_clr_en/phreg  : per-lane allocation, clears the bit at the next edge
//   i_set_en/phreg  : per-lane writeback wakeup, sets the bit at the next edge
//   i_set_all       : exception rollback, every bit becomes ready
//   i_lookup        : four source physical registers being looked up
//   o_rdy           : ready bits for i_lookup, with same-cycle wakeup forwarded
// A register cleared and woken in the same cycle ends up not ready.
// -----------------------------------------------------------------------------
module rename_table_ready_vector
  import rename_table_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [1:0]       i_clr_en,
  input  phreg_t [1:0]     i_clr_phreg,
  input  logic [1:0]       i_set_en,
  input  phreg_t [1:0]     i_set_phreg,
  input  logic             i_set_all,
  input  phreg_t [3:0]     i_lookup,
  output logic [3:0]       o_rdy
);

  logic [NUM_PHISICAL_REGISTERS-1:0] r_ready;
  logic [NUM_PHISICAL_REGISTERS-1:0] w_ready_next;

  // Sets applied before clears so that a clear wins on collision.
  always_comb begin
    w_ready_next = r_ready;
    for (int k = 0; k < 2; k++)
      if (i_set_en[k]) w_ready_next[i_set_phreg[k]] = 1'b1;
    for (int k = 0; k < 2; k++)
      if (i_clr_en[k]) w_ready_next[i_clr_phreg[k]] = 1'b0;
    if (i_set_all) w_ready_next = '1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_ready <= '1;
    else         r_ready <= w_ready_next;
  end

  // Wakeups arriving this cycle are visible to this cycle's lookups.
  always_comb begin
    o_rdy = '0;
    for (int j = 0; j < 4; j++)
      o_rdy[j] = r_ready[i_lookup[j]]
               | (i_set_en[0] && (i_set_phreg[0] == i_lookup[j]))
               | (i_set_en[1] && (i_set_phreg[1] == i_lookup[j]));
  end

endmodule

// File: rtl/rename_table.sv
// -----------------------------------------------------------------------------
// rename_table
// Two-lane register alias table with NUM_CHECKPOINTS speculative map copies and
// a committed map for exception rollback.
//   clk_i, rstn_i            : clock, asynchronous active-low reset
//   src1_i/src2_i/dst_i      : per-lane architectural sources / destination
//   rename_dst_i             : per-lane write-mapping enable
//   new_register_i           : per-lane physical register from the free list
//   ready_i/ready_phreg_i    : writeback wakeups
//   do_checkpoint_i          : snapshot the map after this cycle's renames
//   do_recover_i             : restore version recover_checkpoint_i
//   delete_checkpoint_i      : release the oldest checkpoint
//   commit_write_i/dst/phreg : committed mappings
//   commit_roll_back_i       : restore the committed map
//   src1_o/src2_o, rdy1_o/rdy2_o : source mappings and ready bits
//   old_dst_o                : previous mapping of dst_i (freed at commit)
//   checkpoint_o             : label of the last checkpoint
//   out_of_checkpoints_o     : no checkpoint slot free
// Optional macro RENAME_TABLE_CHECK_EN adds an internal consistency checker
// (error_rename_q); ports are identical either way.
// -----------------------------------------------------------------------------
module rename_table
  import rename_table_pkg::*;
(
  input  logic           clk_i,
  input  logic           rstn_i,
  input  reg_t [1:0]     src1_i,
  input  reg_t [1:0]     src2_i,
  input  reg_t [1:0]     dst_i,
  input  logic [1:0]     rename_dst_i,
  input  phreg_t [1:0]   new_register_i,
  input  logic [1:0]     ready_i,
  input  phreg_t [1:0]   ready_phreg_i,
  input  logic           do_checkpoint_i,
  input  logic           do_recover_i,
  input  logic           delete_checkpoint_i,
  input  checkpoint_ptr  recover_checkpoint_i,
  input  logic [1:0]     commit_write_i,
  input  reg_t [1:0]     commit_dst_i,
  input  phreg_t [1:0]   commit_phreg_i,
  input  logic           commit_roll_back_i,
  output phreg_t [1:0]   src1_o,
  output phreg_t [1:0]   src2_o,
  output logic [1:0]     rdy1_o,
  output logic [1:0]     rdy2_o,
  output phreg_t [1:0]   old_dst_o,
  output checkpoint_ptr  checkpoint_o,
  output logic           out_of_checkpoints_o
);

  phreg_t        r_table  [NUM_CHECKPOINTS][NUM_ISA_REGISTERS];
  phreg_t        r_commit [NUM_ISA_REGISTERS];
  checkpoint_ptr r_head;
  checkpoint_ptr r_tail;
  checkpoint_ptr r_checkpoint;
  num_cp_t       r_num;

  logic          w_block;
  logic [1:0]    w_we;
  logic          w_cp_en;
  logic          w_lane0_def;
  logic          w_byp_src1;
  logic          w_byp_src2;
  logic          w_byp_dst;
  phreg_t [3:0]  w_lookup;
  logic [3:0]    w_rdy;
  phreg_t        w_next_map [NUM_ISA_REGISTERS];

  // Recover and rollback both discard this cycle's renames and checkpoint.
  assign w_block = do_recover_i | commit_roll_back_i;
  always_comb begin
    w_we = '0;
    for (int k = 0; k < 2; k++)
      w_we[k] = rename_dst_i[k] & (dst_i[k] != '0) & ~w_block;
  end
  assign w_cp_en = do_checkpoint_i & (r_num < MAX_LIVE_CP) & ~w_block;

  // Lane 1 sees lane 0's new mapping before it reaches the table.
  assign w_lane0_def = rename_dst_i[0] & (dst_i[0] != '0);
  assign w_byp_src1  = w_lane0_def & (src1_i[1] == dst_i[0]);
  assign w_byp_src2  = w_lane0_def & (src2_i[1] == dst_i[0]);
  assign w_byp_dst   = w_lane0_def & (dst_i[1]  == dst_i[0]);

  assign w_lookup[0] = r_table[r_head][src1_i[0]];
  assign w_lookup[1] = r_table[r_head][src2_i[0]];
  assign w_lookup[2] = r_table[r_head][src1_i[1]];
  assign w_lookup[3] = r_table[r_head][src2_i[1]];

  rename_table_ready_vector u_ready (
    .i_clk       (clk_i),
    .i_rstn      (rstn_i),
    .i_clr_en    (w_we),
    .i_clr_phreg (new_register_i),
    .i_set_en    (ready_i),
    .i_set_phreg (ready_phreg_i),
    .i_set_all   (commit_roll_back_i),
    .i_lookup    (w_lookup),
    .o_rdy       (w_rdy)
  );

  always_comb begin
    src1_o    = '0;
    src2_o    = '0;
    rdy1_o    = '1;
    rdy2_o    = '1;
    old_dst_o = '0;
    // Lane 0
    if (src1_i[0] != '0) begin
      src1_o[0] = w_lookup[0];
      rdy1_o[0] = w_rdy[0];
    end
    if (src2_i[0] != '0) begin
      src2_o[0] = w_lookup[1];
      rdy2_o[0] = w_rdy[1];
    end
    old_dst_o[0] = r_table[r_head][dst_i[0]];
    // Lane 1
    if (src1_i[1] != '0) begin
      src1_o[1] = w_byp_src1 ? new_register_i[0] : w_lookup[2];
      rdy1_o[1] = w_byp_src1 ? 1'b0 : w_rdy[2];
    end
    if (src2_i[1] != '0) begin
      src2_o[1] = w_byp_src2 ? new_register_i[0] : w_lookup[3];
      rdy2_o[1] = w_byp_src2 ? 1'b0 : w_rdy[3];
    end
    old_dst_o[1] = w_byp_dst ? new_register_i[0] : r_table[r_head][dst_i[1]];
  end

  // Current version with this cycle's renames; lane 1 applied last so it wins.
  always_comb begin
    for (int i = 0; i < NUM_ISA_REGISTERS; i++)
      w_next_map[i] = r_table[r_head][i];
    for (int k = 0; k < 2; k++)
      if (w_we[k]) w_next_map[dst_i[k]] = new_register_i[k];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int v = 0; v < NUM_CHECKPOINTS; v++)
        for (int i = 0; i < NUM_ISA_REGISTERS; i++)
          r_table[v][i] <= phreg_t'(i);
    end else if (commit_roll_back_i) begin
      for (int i = 0; i < NUM_ISA_REGISTERS; i++)
        r_table[0][i] <= r_commit[i];
    end else begin
      for (int i = 0; i < NUM_ISA_REGISTERS; i++)
        r_table[r_head][i] <= w_next_map[i];
      if (w_cp_en)
        for (int i = 0; i < NUM_ISA_REGISTERS; i++)
          r_table[cp_inc(r_head)][i] <= w_next_map[i];
    end
  end

  // Committed map; the later lane-1 assignment overrides lane 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_ISA_REGISTERS; i++)
        r_commit[i] <= phreg_t'(i);
    end else if (!commit_roll_back_i) begin
      for (int k = 0; k < 2; k++)
        if (commit_write_i[k] && (commit_dst_i[k] != '0))
          r_commit[commit_dst_i[k]] <= commit_phreg_i[k];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_num        <= '0;
      r_checkpoint <= '0;
    end else if (commit_roll_back_i) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_num        <= '0;
      r_checkpoint <= '0;
    end else begin
      r_checkpoint <= r_head;
      if (delete_checkpoint_i) r_tail <= cp_inc(r_tail);
      if (do_recover_i) begin
        // Live count is recomputed from the pre-delete tail.
        r_head <= recover_checkpoint_i;
        r_num  <= cp_distance(r_tail, recover_checkpoint_i);
      end else begin
        if (w_cp_en) r_head <= cp_inc(r_head);
        r_num <= r_num + num_cp_t'(w_cp_en) - num_cp_t'(delete_checkpoint_i);
      end
    end
  end

  assign checkpoint_o         = r_checkpoint;
  assign out_of_checkpoints_o = (r_num == MAX_LIVE_CP);

`ifdef RENAME_TABLE_CHECK_EN
  logic r_after_rollback;
  logic w_check_err;
  (* keep = "true", mark_debug = "true" *) logic error_rename_q;

  // Flags aliased physical registers in the live version, and any divergence
  // from the committed map in the cycle right after a rollback.
  always_comb begin
    w_check_err = 1'b0;
    for (int i = 1; i < NUM_ISA_REGISTERS; i++)
      for (int j = i + 1; j < NUM_ISA_REGISTERS; j++)
        if (r_table[r_head][i] == r_table[r_head][j]) w_check_err = 1'b1;
    if (r_after_rollback)
      for (int i = 0; i < NUM_ISA_REGISTERS; i++)
        if (r_table[0][i] != r_commit[i]) w_check_err = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_after_rollback <= 1'b0;
      error_rename_q   <= 1'b0;
    end else begin
      r_after_rollback <= commit_roll_back_i;
      error_rename_q   <= w_check_err;
    end
  end
`endif

endmodule
